// File: rtl/div_unit.sv
// div_unit: multi-cycle RV64M divide/remainder unit (DIV/DIVU/REM/REMU and W forms).
// Radix-2 restoring division, one quotient bit per cycle, valid/ready on both sides.
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operator_1,
  input  logic [XLEN-1:0] operator_2,
  input  logic [1:0]      div_op,
  input  logic            word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] div_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [5:0]      r_cnt;
  logic            r_word;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;

  // Operand decode at accept
  logic            w_signed;
  logic            w_is_rem;
  logic [XLEN-1:0] w_a_x;
  logic [XLEN-1:0] w_b_x;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_raw;
  logic [XLEN-1:0] w_spec_res;
  logic            w_accept;

  // Iteration datapath
  logic [XLEN:0]   w_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_rem_n;
  logic [XLEN-1:0] w_quo_n;
  logic            w_last;
  logic [XLEN-1:0] w_sel;
  logic [XLEN-1:0] w_val;
  logic [XLEN-1:0] w_final;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign div_result = r_result;

  assign w_accept = in_valid && (r_state == S_IDLE) && !flush;

  // Sign/zero-extend operands to a common 64-bit view and take magnitudes
  always_comb begin
    w_signed = ~div_op[0];
    w_is_rem = div_op[1];
    if (word) begin
      w_a_x = w_signed ? {{32{operator_1[31]}}, operator_1[31:0]} : {32'b0, operator_1[31:0]};
      w_b_x = w_signed ? {{32{operator_2[31]}}, operator_2[31:0]} : {32'b0, operator_2[31:0]};
    end else begin
      w_a_x = operator_1;
      w_b_x = operator_2;
    end
    w_a_neg  = w_signed && w_a_x[XLEN-1];
    w_b_neg  = w_signed && w_b_x[XLEN-1];
    w_mag_a  = w_a_neg ? (~w_a_x + 1'b1) : w_a_x;
    w_mag_b  = w_b_neg ? (~w_b_x + 1'b1) : w_b_x;
    w_b_zero = word ? (operator_2[31:0] == 32'b0) : (operator_2 == '0);
    w_ovf    = w_signed && (w_b_x == '1) &&
               (word ? (operator_1[31:0] == 32'h8000_0000)
                     : (operator_1 == {1'b1, {(XLEN-1){1'b0}}}));
    w_special = w_b_zero || w_ovf;
    if (w_b_zero) w_spec_raw = w_is_rem ? w_a_x : '1;
    else          w_spec_raw = w_is_rem ? '0 : w_a_x;
    w_spec_res = word ? {{32{w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;
  end

  // One restoring step plus the sign fix-up used on the final step
  always_comb begin
    w_sh    = {r_rem, r_quo[XLEN-1]};
    w_ge    = (w_sh >= {1'b0, r_div});
    w_diff  = w_sh[XLEN-1:0] - r_div;
    w_rem_n = w_ge ? w_diff : w_sh[XLEN-1:0];
    w_quo_n = {r_quo[XLEN-2:0], w_ge};
    w_last  = (r_cnt == (r_word ? 6'd31 : 6'd63));
    w_sel   = r_is_rem ? w_rem_n : w_quo_n;
    w_val   = (r_is_rem ? r_neg_r : r_neg_q) ? (~w_sel + 1'b1) : w_sel;
    w_final = r_word ? {{32{w_val[31]}}, w_val[31:0]} : w_val;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; flush overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = w_special ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Operand latch, iteration and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_word   <= 1'b0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_rem    <= '0;
      // W ops park the 32-bit dividend in the top half so 32 shifts consume it
      r_quo    <= word ? {w_mag_a[31:0], 32'b0} : w_mag_a;
      r_div    <= w_mag_b;
      r_cnt    <= '0;
      r_word   <= word;
      r_is_rem <= w_is_rem;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      if (w_special) r_result <= w_spec_res;
    end else if (r_state == S_CALC && !flush) begin
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      if (w_last) begin
        r_cnt    <= '0;
        r_result <= w_final;
      end else begin
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] operator_1;
  logic [63:0] operator_2;
  logic [1:0]  div_op;
  logic        word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] div_result;

  int checks;
  int errors;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  div_unit #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operator_1 (operator_1),
    .operator_2 (operator_2),
    .div_op     (div_op),
    .word       (word),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .div_result (div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait (bounded) for out_valid; lat = cycles from accept, -1 on timeout
  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output int lat);
    in_valid   = 1'b1;
    div_op     = op;
    word       = w;
    operator_1 = a;
    operator_2 = b;
    tick();
    in_valid   = 1'b0;
    operator_1 = '0;
    operator_2 = '0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      tick();
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_result !== 64'd0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b div_result=%h, required 1 0 0",
               in_ready, out_valid, div_result);
    end
  endtask

  task automatic test_vectors();
    logic [1:0]  t_op  [11];
    logic        t_w   [11];
    logic [63:0] t_a   [11];
    logic [63:0] t_b   [11];
    logic [63:0] t_exp [11];
    int          t_lat [11];
    int lat;
    t_op[0]  = OP_DIVU; t_w[0]  = 0; t_a[0]  = 64'd100; t_b[0] = 64'd7;
    t_exp[0] = 64'd14;                 t_lat[0]  = 65;
    t_op[1]  = OP_REMU; t_w[1]  = 0; t_a[1]  = 64'd100; t_b[1] = 64'd7;
    t_exp[1] = 64'd2;                  t_lat[1]  = 65;
    t_op[2]  = OP_DIV;  t_w[2]  = 0; t_a[2]  = -64'sd20; t_b[2] = 64'd3;
    t_exp[2] = 64'hFFFF_FFFF_FFFF_FFFA; t_lat[2] = 65;
    t_op[3]  = OP_REM;  t_w[3]  = 0; t_a[3]  = -64'sd20; t_b[3] = 64'd3;
    t_exp[3] = 64'hFFFF_FFFF_FFFF_FFFE; t_lat[3] = 65;
    t_op[4]  = OP_REM;  t_w[4]  = 0; t_a[4]  = 64'd20; t_b[4] = -64'sd3;
    t_exp[4] = 64'd2;                  t_lat[4]  = 65;
    t_op[5]  = OP_DIVU; t_w[5]  = 0; t_a[5]  = 64'd5; t_b[5] = 64'd0;
    t_exp[5] = 64'hFFFF_FFFF_FFFF_FFFF; t_lat[5] = 1;
    t_op[6]  = OP_REMU; t_w[6]  = 0; t_a[6]  = 64'd5; t_b[6] = 64'd0;
    t_exp[6] = 64'd5;                  t_lat[6]  = 1;
    t_op[7]  = OP_DIV;  t_w[7]  = 1; t_a[7]  = 64'h0000_0000_8000_0000; t_b[7] = 64'h0000_0000_FFFF_FFFF;
    t_exp[7] = 64'hFFFF_FFFF_8000_0000; t_lat[7] = 1;
    t_op[8]  = OP_DIVU; t_w[8]  = 1; t_a[8]  = 64'h1234_5678_FFFF_FFFF; t_b[8] = 64'hABCD_0000_0000_0001;
    t_exp[8] = 64'hFFFF_FFFF_FFFF_FFFF; t_lat[8] = 33;
    t_op[9]  = OP_REM;  t_w[9]  = 1; t_a[9]  = 64'h0000_0000_FFFF_FFF9; t_b[9] = 64'd2;
    t_exp[9] = 64'hFFFF_FFFF_FFFF_FFFF; t_lat[9] = 33;
    t_op[10] = OP_DIV;  t_w[10] = 0; t_a[10] = 64'h8000_0000_0000_0000; t_b[10] = '1;
    t_exp[10] = 64'h8000_0000_0000_0000; t_lat[10] = 1;
    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], t_w[i], t_a[i], t_b[i], lat);
      checks++;
      if (lat !== t_lat[i]) begin
        errors++;
        $display("FAIL vec%0d latency: got %0d, required %0d", i, lat, t_lat[i]);
      end
      checks++;
      if (div_result !== t_exp[i]) begin
        errors++;
        $display("FAIL vec%0d result: got %h, required %h", i, div_result, t_exp[i]);
      end
      consume();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d handoff: in_ready=%b out_valid=%b, required 1 0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    issue(OP_DIVU, 1'b0, 64'd100, 64'd7, lat);
    checks++;
    if (lat !== 65 || div_result !== 64'd14) begin
      errors++;
      $display("FAIL bp_first: latency %0d result %h, required 65 and 14", lat, div_result);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || div_result !== 64'd14) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush_blocks_accept();
    in_valid   = 1'b1;
    flush      = 1'b1;
    div_op     = OP_DIVU;
    word       = 1'b0;
    operator_1 = 64'd9;
    operator_2 = 64'd0;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  // Abort at CALC iteration 20 by flush (use_rst=0) or reset (use_rst=1)
  task automatic test_abort(input logic use_rst);
    int lat;
    int seen;
    in_valid   = 1'b1;
    div_op     = OP_DIVU;
    word       = 1'b0;
    operator_1 = 64'd1000;
    operator_2 = 64'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort%0d_busy: in_ready=%b out_valid=%b, required 0 0",
               use_rst, in_ready, out_valid);
    end
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort%0d_idle: in_ready=%b out_valid=%b, required 1 0",
               use_rst, in_ready, out_valid);
    end
    if (use_rst) begin
      checks++;
      if (div_result !== 64'd0) begin
        errors++;
        $display("FAIL abort_rst_result: got %h, required 0", div_result);
      end
    end
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort%0d_novalid: out_valid seen %0d cycles, required 0", use_rst, seen);
    end
    issue(OP_DIVU, 1'b0, 64'd9, 64'd3, lat);
    checks++;
    if (lat !== 65 || div_result !== 64'd3) begin
      errors++;
      $display("FAIL abort%0d_after: latency %0d result %h, required 65 and 3",
               use_rst, lat, div_result);
    end
    consume();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    operator_1 = '0;
    operator_2 = '0;
    div_op     = '0;
    word       = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    tick();
    test_reset();
    test_vectors();
    test_backpressure();
    test_flush_blocks_accept();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV64M integer divide/remainder unit that sits beside the ALU in the execute stage. It consumes the same `operator_1`/`operator_2` pair the ALU receives and hands its result to the writeback select, which takes it in place of `alu_result` for DIV/DIVU/REM/REMU and their W variants. It uses a radix-2 restoring algorithm, one quotient bit per cycle, with valid/ready handshakes on both sides so the pipeline control can stall around it.

## Interface
- `XLEN`, 64: datapath width. Only 64 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and op are valid this cycle.
- `in_ready`  out  1  unit can accept an operation; high only in IDLE.
- `operator_1`  in  XLEN  dividend.
- `operator_2`  in  XLEN  divisor.
- `div_op`  in  2  operation: 0 = DIV, 1 = DIVU, 2 = REM, 3 = REMU.
- `word`  in  1  selects the W variant (32-bit operation, result sign-extended to 64).
- `flush`  in  1  abandons any in-flight operation.
- `out_valid`  out  1  `div_result` is valid.
- `out_ready`  in  1  consumer accepts the result.
- `div_result`  out  XLEN  quotient or remainder.

## Operation
- **States**
  - IDLE: `in_ready` = 1.
  - CALC: iterating, one quotient bit per cycle.
  - DONE: `out_valid` = 1.
- **Accept**
  - Occurs when `in_valid && in_ready`. On that edge the unit latches the op, `word`, the signedness, and the operand magnitudes.
  - W ops take bits [31:0] of each operand.
  - Signed ops (DIV/REM) use the absolute value of each operand.
- **Special cases** (decided at accept; go IDLE→DONE directly, with no CALC)
  - Divisor == 0: quotient = all ones (-1); remainder = dividend.
  - Signed overflow (dividend = most-negative value, divisor = -1): quotient = dividend; remainder = 0.
  - For W ops, "zero", "most-negative" and "-1" are evaluated on the 32-bit values, and the special results are also taken from the 32-bit values.
- **CALC**
  - Iteration count N = 64, or 32 when `word` = 1.
  - Each cycle: shift {rem, quo} left by 1 and trial-subtract the divisor.
    - If the result is ≥ 0: keep the difference and set quotient bit 1.
    - Otherwise: restore and set quotient bit 0.
  - A counter runs 0..N-1. On the last iteration, go to DONE.
- **Sign fix-up** (applied when entering DONE)
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- **Result format**
  - W ops: `div_result` = sign-extend(result[31:0]). This applies to DIVUW and REMUW as well.
  - `div_result` is registered and held stable while `out_valid && !out_ready`.
- **DONE exit**: on `out_valid && out_ready`, go to IDLE.
- **Flush**
  - `flush` = 1 in any state forces IDLE at the next edge and clears `out_valid`.
  - If `flush` and `in_valid` are high in the same cycle, the operation is not accepted.
  - Flush has priority over the output handshake.
- **Reset**
  - `rst` forces IDLE, `out_valid` = 0, `div_result` = 0, counter = 0.
  - From the first cycle after reset, `in_ready` = 1.
  - Reset mid-CALC or mid-DONE discards the operation with no output.

## Timing
- Accept at edge T.
- Normal op: CALC occupies cycles T+1 .. T+N; `out_valid` is high from cycle T+N+1. This gives 65 cycles for 64-bit ops and 33 cycles for W ops, measured from accept to the first `out_valid` cycle.
- Special case: `out_valid` is high in cycle T+1.
- Result handshake at edge R: `in_ready` = 1 in cycle R+1. There is no back-to-back accept in the same cycle as result handoff.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from any input.
- `div_result` changes only on the transition into DONE or on reset.

## Test plan
- DIVU 100 / 7: `out_valid` first high 65 cycles after accept, `div_result` = 14. REMU 100 % 7 → 2.
- DIV -20 / 3 → 0xFFFFFFFFFFFFFFFA (-6). REM -20 % 3 → 0xFFFFFFFFFFFFFFFE (-2). REM 20 % -3 → 2.
- Divide by zero:
  - DIVU 5 / 0 → 0xFFFFFFFFFFFFFFFF; REMU 5 % 0 → 5; both with `out_valid` at T+1.
  - DIVW 0x80000000 / 0xFFFFFFFF (32-bit overflow) → 0xFFFFFFFF80000000 at T+1.
- W ops:
  - DIVUW 0x12345678_FFFFFFFF / 1 → 0xFFFFFFFFFFFFFFFF, with 33-cycle latency; upper bits of the operand are ignored.
  - REMW -7 % 2 → 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold `out_ready` = 0 for 10 cycles after `out_valid`. `div_result` and `out_valid` stay stable and `in_ready` stays 0. Raise `out_ready`; `in_ready` = 1 the following cycle.
- Abort:
  - Assert `flush` at CALC iteration 20: next cycle IDLE, `out_valid` never rises, and a subsequent DIVU 9 / 3 returns 3 with normal latency.
  - Repeat the same mid-operation abort using `rst` instead of `flush`: same result, plus `div_result` = 0.
